// File: rtl/dp_issue_pkg.sv
// dp_issue_pkg: shared definitions for the dp_issue sequencer.
//   - state_e      : sequencer states (IDLE, READ, SETUP, FIRE, WB)
//   - field bounds : bit positions of the A32 data-processing word
//   - Cond*        : condition code constants
//   - Op*          : data-processing opcode constants
//   - writes_pc()  : true when the word targets r15
package dp_issue_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StSetup = 3'd2,
        StFire  = 3'd3,
        StWb    = 3'd4
    } state_e;

    // Instruction field bit positions
    localparam int unsigned CondMsb  = 31;
    localparam int unsigned CondLsb  = 28;
    localparam int unsigned ImmBit   = 25;
    localparam int unsigned OpMsb    = 24;
    localparam int unsigned OpLsb    = 21;
    localparam int unsigned SBit     = 20;
    localparam int unsigned RnLsb    = 16;
    localparam int unsigned RdMsb    = 15;
    localparam int unsigned RdLsb    = 12;
    localparam int unsigned Imm12Msb = 11;
    localparam int unsigned ShMsb    = 11;
    localparam int unsigned ShLsb    = 7;
    localparam int unsigned StypeMsb = 6;
    localparam int unsigned StypeLsb = 5;
    localparam int unsigned RmLsb    = 0;

    // Condition codes
    localparam logic [3:0] CondEq = 4'h0;
    localparam logic [3:0] CondNe = 4'h1;
    localparam logic [3:0] CondCs = 4'h2;
    localparam logic [3:0] CondCc = 4'h3;
    localparam logic [3:0] CondMi = 4'h4;
    localparam logic [3:0] CondPl = 4'h5;
    localparam logic [3:0] CondVs = 4'h6;
    localparam logic [3:0] CondVc = 4'h7;
    localparam logic [3:0] CondHi = 4'h8;
    localparam logic [3:0] CondLs = 4'h9;
    localparam logic [3:0] CondGe = 4'ha;
    localparam logic [3:0] CondLt = 4'hb;
    localparam logic [3:0] CondGt = 4'hc;
    localparam logic [3:0] CondLe = 4'hd;
    localparam logic [3:0] CondAl = 4'he;
    localparam logic [3:0] CondNv = 4'hf;

    // Data-processing opcodes
    localparam logic [3:0] OpAnd = 4'h0;
    localparam logic [3:0] OpEor = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpRsb = 4'h3;
    localparam logic [3:0] OpAdd = 4'h4;
    localparam logic [3:0] OpAdc = 4'h5;
    localparam logic [3:0] OpSbc = 4'h6;
    localparam logic [3:0] OpRsc = 4'h7;
    localparam logic [3:0] OpTst = 4'h8;
    localparam logic [3:0] OpTeq = 4'h9;
    localparam logic [3:0] OpCmp = 4'ha;
    localparam logic [3:0] OpCmn = 4'hb;
    localparam logic [3:0] OpOrr = 4'hc;
    localparam logic [3:0] OpMov = 4'hd;
    localparam logic [3:0] OpBic = 4'he;
    localparam logic [3:0] OpMvn = 4'hf;

    localparam logic [3:0] RegPc = 4'hf;

    function automatic logic writes_pc(input logic [31:0] word);
        return word[RdMsb:RdLsb] == RegPc;
    endfunction

endpackage

// File: rtl/dp_issue_cond_check.sv
// dp_issue_cond_check: combinational condition-code evaluation.
//   cond  in  4  condition field of the instruction
//   carry in  1  C flag
//   zero  in  1  Z flag
//   neg   in  1  N flag
//   pass  out 1  instruction should execute
// There is no V flag here, so every V-dependent code and NV fail.
module dp_issue_cond_check
    import dp_issue_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       carry,
    input  logic       zero,
    input  logic       neg,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            CondEq:  pass = zero;
            CondNe:  pass = !zero;
            CondCs:  pass = carry;
            CondCc:  pass = !carry;
            CondMi:  pass = neg;
            CondPl:  pass = !neg;
            CondHi:  pass = carry && !zero;
            CondLs:  pass = !carry || zero;
            CondAl:  pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue.sv
// dp_issue: issue/writeback sequencer for data-processing ops.
// Build option: COND_EXEC_EN enables condition-code evaluation in READ; without it every
// instruction executes and cond_skip is tied low.
// Ports:
//   clk, rst (async, active-low)
//   instr_valid/instr_ready/instr     : instruction handshake
//   rf_raddr_n/m, rf_rdata_n/m        : register-file read (combinational)
//   en_inst                           : one-cycle execute strobe
//   imm, s, opcode, rn_val, rm_val,
//   imm_operand, imm_shift, stype     : decoded fields and latched operands
//   carry_flag, zero_flag, neg_flag   : architectural flags fed back to the unit
//   alu_rd, alu_carry/zero/neg        : execute unit results
//   rf_we, rf_waddr, rf_wdata         : writeback port
//   retire, cond_skip                 : completion pulse and not-executed qualifier
module dp_issue
    import dp_issue_pkg::*;
#(
    parameter int unsigned RF_AW = 4,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [RF_AW-1:0] rf_raddr_n,
    output logic [RF_AW-1:0] rf_raddr_m,
    input  logic [DW-1:0]    rf_rdata_n,
    input  logic [DW-1:0]    rf_rdata_m,
    output logic             en_inst,
    output logic             imm,
    output logic             s,
    output logic [3:0]       opcode,
    output logic [DW-1:0]    rn_val,
    output logic [DW-1:0]    rm_val,
    output logic [11:0]      imm_operand,
    output logic [4:0]       imm_shift,
    output logic [1:0]       stype,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             neg_flag,
    input  logic [DW-1:0]    alu_rd,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic             retire,
    output logic             cond_skip
);

    state_e          state_q, state_d;
    logic [31:0]     instr_q;
    logic [DW-1:0]   rn_val_q, rm_val_q;
    logic            carry_q, zero_q, neg_q;
    logic            cond_pass;
    logic            skip_pulse;

`ifdef COND_EXEC_EN
    logic skip_q;

    dp_issue_cond_check u_cond_check (
        .cond  (instr_q[CondMsb:CondLsb]),
        .carry (carry_q),
        .zero  (zero_q),
        .neg   (neg_q),
        .pass  (cond_pass)
    );

    // Failed condition retires straight from READ as a one-cycle skip pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= (state_q == StRead) && !cond_pass;
        end
    end

    assign skip_pulse = skip_q;
`else
    logic unused_cond;

    assign cond_pass   = 1'b1;
    assign skip_pulse  = 1'b0;
    assign unused_cond = ^instr_q[CondMsb:CondLsb];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (instr_valid) state_d = StRead;
            StRead:  state_d = cond_pass ? StSetup : StIdle;
            StSetup: state_d = StFire;
            StFire:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            rn_val_q <= '0;
            rm_val_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
            end
            // Operands are captured before WB, so Rd aliasing Rn/Rm is harmless.
            if (state_q == StRead) begin
                rn_val_q <= rf_rdata_n;
                rm_val_q <= rf_rdata_m;
            end
            // The unit already holds the old flags when S=0.
            if (state_q == StWb) begin
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
                neg_q   <= alu_neg;
            end
        end
    end

    // Outputs are decoded straight from registered state and fields.
    assign instr_ready = (state_q == StIdle);
    assign rf_raddr_n  = (state_q == StRead) ? instr_q[RnLsb +: RF_AW] : '0;
    assign rf_raddr_m  = (state_q == StRead) ? instr_q[RmLsb +: RF_AW] : '0;
    assign en_inst     = (state_q == StFire);

    assign imm         = instr_q[ImmBit];
    assign s           = instr_q[SBit];
    assign opcode      = instr_q[OpMsb:OpLsb];
    assign imm_operand = instr_q[Imm12Msb:0];
    assign imm_shift   = instr_q[ShMsb:ShLsb];
    assign stype       = instr_q[StypeMsb:StypeLsb];
    assign rn_val      = rn_val_q;
    assign rm_val      = rm_val_q;

    assign carry_flag  = carry_q;
    assign zero_flag   = zero_q;
    assign neg_flag    = neg_q;

    // r15 is never written here; the flags and retire still behave normally.
    assign rf_we       = (state_q == StWb) && !writes_pc(instr_q);
    assign rf_waddr    = (state_q == StWb) ? instr_q[RdLsb +: RF_AW] : '0;
    assign rf_wdata    = (state_q == StWb) ? alu_rd : '0;
    assign retire      = (state_q == StWb) || skip_pulse;
    assign cond_skip   = skip_pulse;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_q[27:26], instr_q[4]};

endmodule

// File: tb/tb_dp_issue.sv
// tb_dp_issue: directed self-checking bench for dp_issue.
// Cycle n counts from the accepting edge: cycle 1 = READ, cycle 3 = FIRE, cycle 4 = WB.
// Build option COND_EXEC_EN selects the conditional-execution scenario.
module tb_dp_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr_n, rf_raddr_m;
    logic [31:0] rf_rdata_n, rf_rdata_m;
    logic        en_inst, imm, s;
    logic [3:0]  opcode;
    logic [31:0] rn_val, rm_val;
    logic [11:0] imm_operand;
    logic [4:0]  imm_shift;
    logic [1:0]  stype;
    logic        carry_flag, zero_flag, neg_flag;
    logic [31:0] alu_rd;
    logic        alu_carry, alu_zero, alu_neg;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire, cond_skip;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    logic load_rf = 1'b0;
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    dp_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr_n  (rf_raddr_n),
        .rf_raddr_m  (rf_raddr_m),
        .rf_rdata_n  (rf_rdata_n),
        .rf_rdata_m  (rf_rdata_m),
        .en_inst     (en_inst),
        .imm         (imm),
        .s           (s),
        .opcode      (opcode),
        .rn_val      (rn_val),
        .rm_val      (rm_val),
        .imm_operand (imm_operand),
        .imm_shift   (imm_shift),
        .stype       (stype),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
        .alu_rd      (alu_rd),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .retire      (retire),
        .cond_skip   (cond_skip)
    );

    function automatic logic [31:0] rf_init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        case (i)
            1:       return 32'h123456F8;
            3:       return 32'hFFFF0FF0;
            5:       return 32'h00000ABC;
            default: return {4{b}};
        endcase
    endfunction

    assign rf_rdata_n = rf[rf_raddr_n];
    assign rf_rdata_m = rf[rf_raddr_m];

    // Execute-unit model: AND/ORR with LSL/LSR register operand, flags only when S=1.
    logic [31:0] op2, res;
    always_comb begin
        op2 = imm ? {20'd0, imm_operand}
                  : ((stype == 2'd0) ? (rm_val << imm_shift) : (rm_val >> imm_shift));
        case (opcode)
            4'h0:    res = rn_val & op2;
            4'hc:    res = rn_val | op2;
            default: res = 32'd0;
        endcase
        alu_rd    = res;
        alu_zero  = s ? (res == 32'd0) : zero_flag;
        alu_neg   = s ? res[31] : neg_flag;
        alu_carry = carry_flag;
    end

    always @(posedge clk) begin
        if (load_rf) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init_val(i);
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
        if (rf_we)   we_cnt <= we_cnt + 1;
        if (en_inst) en_cnt <= en_cnt + 1;
    end

    // Waits (bounded) for instr_ready, offers one word, returns at the cycle-1 negedge.
    task automatic send(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1'b1;
        end
        if (ok) begin
            instr       = w;
            instr_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; instr_valid = 1'b0; instr = 32'd0; load_rf = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", instr_ready); end
        total++; if (en_inst !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", en_inst); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", rf_we); end
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b want=0", retire); end
        total++; if ({carry_flag, zero_flag, neg_flag} !== 3'b000) begin
            bad++; $display("FAIL rst_flags got=%b want=000", {carry_flag, zero_flag, neg_flag}); end
        total++; if (rn_val !== 32'd0) begin bad++; $display("FAIL rst_rn got=%h want=0", rn_val); end
        load_rf = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_imm();
        bit ok;
        send(32'hE21120F0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL imm_accept got=%b want=1", ok); end
        total++; if (rf_raddr_n !== 4'd1) begin bad++; $display("FAIL imm_raddr_n got=%h want=1", rf_raddr_n); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL imm_ready_c1 got=%b want=0", instr_ready); end
        total++; if (en_inst !== 1'b0) begin bad++; $display("FAIL imm_en_c1 got=%b want=0", en_inst); end
        @(negedge clk);
        total++; if (en_inst !== 1'b0) begin bad++; $display("FAIL imm_en_c2 got=%b want=0", en_inst); end
        @(negedge clk);
        total++; if (en_inst !== 1'b1) begin bad++; $display("FAIL imm_en_c3 got=%b want=1", en_inst); end
        total++; if ({imm, s, opcode} !== 6'b110000) begin
            bad++; $display("FAIL imm_fields got=%b want=110000", {imm, s, opcode}); end
        total++; if (imm_operand !== 12'h0F0) begin bad++; $display("FAIL imm_operand got=%h want=0f0", imm_operand); end
        total++; if (rn_val !== 32'h123456F8) begin bad++; $display("FAIL imm_rn got=%h want=123456f8", rn_val); end
        @(negedge clk);
        total++; if (en_inst !== 1'b0) begin bad++; $display("FAIL imm_en_c4 got=%b want=0", en_inst); end
        total++; if ({rf_we, retire, cond_skip} !== 3'b110) begin
            bad++; $display("FAIL imm_wb_c4 got=%b want=110", {rf_we, retire, cond_skip}); end
        total++; if (rf_waddr !== 4'd2) begin bad++; $display("FAIL imm_waddr got=%h want=2", rf_waddr); end
        total++; if (rf_wdata !== 32'h000000F0) begin bad++; $display("FAIL imm_wdata got=%h want=f0", rf_wdata); end
        @(negedge clk);
        total++; if ({instr_ready, retire} !== 2'b10) begin
            bad++; $display("FAIL imm_c5 got=%b want=10", {instr_ready, retire}); end
        total++; if (rf[2] !== 32'h000000F0) begin bad++; $display("FAIL imm_r2 got=%h want=f0", rf[2]); end
        total++; if ({zero_flag, neg_flag} !== 2'b00) begin
            bad++; $display("FAIL imm_flags got=%b want=00", {zero_flag, neg_flag}); end
    endtask

    task automatic test_reg();
        bit ok;
        // AND r2,r1,#0 with S sets Z so the S=0 op below can show it is left alone.
        send(32'hE2112000, ok);
        repeat (4) @(negedge clk);
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL reg_pre_z got=%b want=1", zero_flag); end
        send(32'hE0034205, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL reg_accept got=%b want=1", ok); end
        total++; if (rf_raddr_m !== 4'd5) begin bad++; $display("FAIL reg_raddr_m got=%h want=5", rf_raddr_m); end
        repeat (2) @(negedge clk);
        total++; if ({imm, s, imm_shift, stype} !== 9'b00_00100_00) begin
            bad++; $display("FAIL reg_fields got=%b want=000010000", {imm, s, imm_shift, stype}); end
        total++; if (rm_val !== 32'h00000ABC) begin bad++; $display("FAIL reg_rm got=%h want=abc", rm_val); end
        total++; if (rn_val !== 32'hFFFF0FF0) begin bad++; $display("FAIL reg_rn got=%h want=ffff0ff0", rn_val); end
        @(negedge clk);
        total++; if (rf_waddr !== 4'd4) begin bad++; $display("FAIL reg_waddr got=%h want=4", rf_waddr); end
        total++; if (rf_wdata !== 32'h00000BC0) begin bad++; $display("FAIL reg_wdata got=%h want=bc0", rf_wdata); end
        @(negedge clk);
        total++; if (rf[4] !== 32'h00000BC0) begin bad++; $display("FAIL reg_r4 got=%h want=bc0", rf[4]); end
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL reg_z_kept got=%b want=1", zero_flag); end
    endtask

    task automatic test_rd15();
        bit ok;
        int we_before;
        we_before = we_cnt;
        send(32'hE211F0F0, ok);
        repeat (3) @(negedge clk);
        total++; if ({retire, rf_we} !== 2'b10) begin
            bad++; $display("FAIL rd15_c4 got=%b want=10", {retire, rf_we}); end
        @(negedge clk);
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL rd15_z got=%b want=0", zero_flag); end
        total++; if (we_cnt !== we_before) begin bad++; $display("FAIL rd15_we got=%0d want=%0d", we_cnt, we_before); end
        total++; if (rf[15] !== 32'h0F0F0F0F) begin bad++; $display("FAIL rd15_r15 got=%h want=0f0f0f0f", rf[15]); end
    endtask

    task automatic test_back_to_back();
        logic [12:1] rdy_v, ret_v, en_v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1'b1;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", ok); end
        instr = 32'hE21160F0; instr_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rdy_v[c] = instr_ready;
            ret_v[c] = retire;
            en_v[c]  = en_inst;
            if (c == 1) instr = 32'hE0037205;
            if (c == 6) instr_valid = 1'b0;
        end
        total++; if (rdy_v !== 12'hE10) begin bad++; $display("FAIL b2b_ready_vec got=%h want=e10", rdy_v); end
        total++; if (ret_v !== 12'h108) begin bad++; $display("FAIL b2b_retire_vec got=%h want=108", ret_v); end
        total++; if (en_v !== 12'h084) begin bad++; $display("FAIL b2b_en_vec got=%h want=084", en_v); end
        total++; if (rf[6] !== 32'h000000F0) begin bad++; $display("FAIL b2b_r6 got=%h want=f0", rf[6]); end
        total++; if (rf[7] !== 32'h00000BC0) begin bad++; $display("FAIL b2b_r7 got=%h want=bc0", rf[7]); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        int we_before;
        send(32'hE2112000, ok);
        repeat (4) @(negedge clk);
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL mid_pre_z got=%b want=1", zero_flag); end
        we_before = we_cnt;
        send(32'hE21180F0, ok);
        repeat (2) @(negedge clk);
        total++; if (en_inst !== 1'b1) begin bad++; $display("FAIL mid_fire got=%b want=1", en_inst); end
        rst = 1'b0;
        #1;
        total++; if ({en_inst, rf_we, retire, instr_ready} !== 4'b0001) begin
            bad++; $display("FAIL mid_outs got=%b want=0001", {en_inst, rf_we, retire, instr_ready}); end
        total++; if ({zero_flag, rn_val, imm_operand} !== 45'd0) begin
            bad++; $display("FAIL mid_clear got=%b/%h/%h want=0", zero_flag, rn_val, imm_operand); end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (we_cnt !== we_before) begin bad++; $display("FAIL mid_we got=%0d want=%0d", we_cnt, we_before); end
        total++; if (rf[8] !== 32'h08080808) begin bad++; $display("FAIL mid_r8 got=%h want=08080808", rf[8]); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b want=1", instr_ready); end
    endtask

`ifdef COND_EXEC_EN
    task automatic test_cond();
        bit ok;
        int en_before, we_before;
        en_before = en_cnt;
        we_before = we_cnt;
        send(32'h021120F0, ok);
        @(negedge clk);
        total++; if ({retire, cond_skip, en_inst} !== 3'b110) begin
            bad++; $display("FAIL cond_skip_c2 got=%b want=110", {retire, cond_skip, en_inst}); end
        @(negedge clk);
        total++; if ({retire, cond_skip, instr_ready} !== 3'b001) begin
            bad++; $display("FAIL cond_skip_c3 got=%b want=001", {retire, cond_skip, instr_ready}); end
        total++; if (en_cnt !== en_before || we_cnt !== we_before) begin
            bad++; $display("FAIL cond_no_exec got=%0d/%0d want=%0d/%0d", en_cnt, we_cnt, en_before, we_before); end
        total++; if (rf[2] !== 32'd0) begin bad++; $display("FAIL cond_r2_kept got=%h want=0", rf[2]); end
        // VS can never pass without a V flag.
        send(32'h621120F0, ok);
        @(negedge clk);
        total++; if (cond_skip !== 1'b1) begin bad++; $display("FAIL cond_vs got=%b want=1", cond_skip); end
        send(32'hE2112000, ok);
        repeat (4) @(negedge clk);
        send(32'h021120F0, ok);
        repeat (2) @(negedge clk);
        total++; if (en_inst !== 1'b1) begin bad++; $display("FAIL cond_eq_en got=%b want=1", en_inst); end
        @(negedge clk);
        total++; if ({retire, cond_skip, rf_we} !== 3'b101) begin
            bad++; $display("FAIL cond_eq_wb got=%b want=101", {retire, cond_skip, rf_we}); end
        @(negedge clk);
        total++; if (rf[2] !== 32'h000000F0) begin bad++; $display("FAIL cond_eq_r2 got=%h want=f0", rf[2]); end
    endtask
`else
    task automatic test_cond();
        bit ok;
        // Z=0 after reset: EQ would fail, but cond is ignored in this build.
        send(32'h021120F0, ok);
        @(negedge clk);
        total++; if ({retire, cond_skip} !== 2'b00) begin
            bad++; $display("FAIL nocond_c2 got=%b want=00", {retire, cond_skip}); end
        @(negedge clk);
        total++; if (en_inst !== 1'b1) begin bad++; $display("FAIL nocond_en got=%b want=1", en_inst); end
        @(negedge clk);
        total++; if ({retire, cond_skip, rf_we} !== 3'b101) begin
            bad++; $display("FAIL nocond_wb got=%b want=101", {retire, cond_skip, rf_we}); end
        @(negedge clk);
        total++; if (rf[2] !== 32'h000000F0) begin bad++; $display("FAIL nocond_r2 got=%h want=f0", rf[2]); end
    endtask
`endif

    initial begin
        test_reset();
        test_imm();
        test_reg();
        test_rd15();
        test_back_to_back();
        test_reset_midop();
        test_cond();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
